// File: rtl/apb2axi_bridge.sv
// apb2axi_bridge: APB3 completer driving one single-beat AXI4 access.
// Optional watchdog + drain path: define APB2AXI_TIMEOUT_EN.
module apb2axi_bridge #(
  parameter int ID_WIDTH       = 7,
  parameter int AXI_ID         = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_psel,
  input  logic                i_penable,
  input  logic                i_pwrite,
  input  logic [31:0]         i_paddr,
  input  logic [31:0]         i_pwdata,
  output logic [31:0]         o_prdata,
  output logic                o_pready,
  output logic                o_pslverr,
  output logic [ID_WIDTH-1:0] o_awid,
  output logic [31:0]         o_awaddr,
  output logic [7:0]          o_awlen,
  output logic [2:0]          o_awsize,
  output logic [1:0]          o_awburst,
  output logic                o_awvalid,
  input  logic                i_awready,
  output logic [31:0]         o_wdata,
  output logic [3:0]          o_wstrb,
  output logic                o_wlast,
  output logic                o_wvalid,
  input  logic                i_wready,
  input  logic [ID_WIDTH-1:0] i_bid,
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready,
  output logic [ID_WIDTH-1:0] o_arid,
  output logic [31:0]         o_araddr,
  output logic [7:0]          o_arlen,
  output logic [2:0]          o_arsize,
  output logic [1:0]          o_arburst,
  output logic                o_arvalid,
  input  logic                i_arready,
  input  logic [ID_WIDTH-1:0] i_rid,
  input  logic [31:0]         i_rdata,
  input  logic [1:0]          i_rresp,
  input  logic                i_rlast,
  input  logic                i_rvalid,
  output logic                o_rready
);

`ifdef APB2AXI_TIMEOUT_EN
  typedef enum logic [2:0] {
    IDLE, WR, WR_RESP, RD, RD_DATA, DONE, DRAIN
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, WR, WR_RESP, RD, RD_DATA, DONE
  } state_t;
`endif

  localparam logic [ID_WIDTH-1:0] ID = ID_WIDTH'(AXI_ID);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state, nxt;
  logic [31:0] addr_q, wdata_q, prdata_q;
  logic        err_q, first_q;
  logic        aw_valid, w_valid, ar_valid;
  logic        capture, b_err, r_err;

  assign capture = (state == IDLE) && i_psel && i_penable;
  assign b_err = i_bresp[1] || (i_bid != ID);
  assign r_err = i_rresp[1] || (i_rid != ID) || !i_rlast;

`ifdef APB2AXI_TIMEOUT_EN
  localparam logic [31:0] LIMIT = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] cnt;
  logic        tmo_q, resp_seen, tmo_fire;
  logic        busy, pending, b_hs, r_hs;

  assign busy = (state == WR) || (state == WR_RESP)
             || (state == RD) || (state == RD_DATA);
  assign pending = aw_valid || w_valid || ar_valid || !resp_seen;
  assign b_hs = i_bvalid && o_bready;
  assign r_hs = i_rvalid && o_rready;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next-state: handshake sequencing, watchdog override last.
  always_comb begin
    nxt = state;
`ifdef APB2AXI_TIMEOUT_EN
    tmo_fire = 1'b0;
`endif
    unique case (state)
      IDLE:
        if (i_psel && i_penable)
          nxt = i_pwrite ? WR : RD;
      WR:
        if ((!aw_valid || i_awready) &&
            (!w_valid || i_wready))
          nxt = WR_RESP;
      WR_RESP: if (i_bvalid) nxt = DONE;
      RD:      if (i_arready) nxt = RD_DATA;
      RD_DATA: if (i_rvalid && i_rlast) nxt = DONE;
`ifdef APB2AXI_TIMEOUT_EN
      DONE:  nxt = tmo_q ? DRAIN : IDLE;
      DRAIN: if (!pending) nxt = IDLE;
`else
      DONE:  nxt = IDLE;
`endif
      default: nxt = IDLE;
    endcase
`ifdef APB2AXI_TIMEOUT_EN
    if (busy && cnt == LIMIT && nxt != DONE) begin
      tmo_fire = 1'b1;
      nxt = DONE;
    end
`endif
  end

  // Request capture, valid tracking, response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      prdata_q <= '0;
      err_q    <= 1'b0;
      first_q  <= 1'b0;
      aw_valid <= 1'b0;
      w_valid  <= 1'b0;
      ar_valid <= 1'b0;
    end else begin
      if (capture) begin
        addr_q   <= i_paddr;
        wdata_q  <= i_pwdata;
        aw_valid <= i_pwrite;
        w_valid  <= i_pwrite;
        ar_valid <= !i_pwrite;
        first_q  <= 1'b1;
        err_q    <= 1'b0;
      end else begin
        if (i_awready) aw_valid <= 1'b0;
        if (i_wready)  w_valid  <= 1'b0;
        if (i_arready) ar_valid <= 1'b0;
      end
      if (state == WR_RESP && i_bvalid)
        err_q <= b_err;
      if (state == RD_DATA && i_rvalid && first_q) begin
        prdata_q <= i_rdata;
        err_q    <= r_err;
        first_q  <= 1'b0;
      end
`ifdef APB2AXI_TIMEOUT_EN
      if (tmo_fire) begin
        prdata_q <= 32'hDEAD_BEEF;
        err_q    <= 1'b1;
      end
`endif
    end
  end

`ifdef APB2AXI_TIMEOUT_EN
  // Watchdog count and outstanding-response tracking for drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      tmo_q     <= 1'b0;
      resp_seen <= 1'b0;
    end else if (capture) begin
      cnt       <= '0;
      tmo_q     <= 1'b0;
      resp_seen <= 1'b0;
    end else begin
      if (busy) cnt <= cnt + 32'd1;
      if (tmo_fire) tmo_q <= 1'b1;
      if (b_hs || (r_hs && i_rlast))
        resp_seen <= 1'b1;
    end
  end

  assign o_bready = (state == WR_RESP) || (state == DRAIN);
  assign o_rready = (state == RD_DATA) || (state == DRAIN);
`else
  assign o_bready = (state == WR_RESP);
  assign o_rready = (state == RD_DATA);
`endif

  assign o_pready  = (state == DONE);
  assign o_pslverr = (state == DONE) && err_q;
  assign o_prdata  = prdata_q;

  assign o_awid    = ID;
  assign o_awaddr  = addr_q & 32'hFFFF_FFFC;
  assign o_awlen   = 8'd0;
  assign o_awsize  = 3'b010;
  assign o_awburst = 2'b01;
  assign o_awvalid = aw_valid;
  assign o_wdata   = wdata_q;
  assign o_wstrb   = 4'hF;
  assign o_wlast   = 1'b1;
  assign o_wvalid  = w_valid;
  assign o_arid    = ID;
  assign o_araddr  = addr_q & 32'hFFFF_FFFC;
  assign o_arlen   = 8'd0;
  assign o_arsize  = 3'b010;
  assign o_arburst = 2'b01;
  assign o_arvalid = ar_valid;

endmodule
